w5300_reg_cmd_seq: RTL and testbench

//  Register-access sequencer directly upstream of the W5300 parallel r/w interface (_w5300_parallel_if_rw).

---
 rtl/w5300_reg_cmd_seq.sv | 205 ++++++++++++++++++++
 tb/tb_w5300_reg_cmd_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_reg_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : w5300_reg_cmd_seq
// Function : Buffers W5300 word read/write commands in a small FIFO and issues
//            them one at a time to the parallel r/w interface, returning one
//            tagged response per command with data or error.
// Revision : 1.0  initial release
// ============================================================================
module w5300_reg_cmd_seq #(
    parameter int FIFO_AW      = 2,
    parameter int TAG_W        = 4,
    parameter int BUSY_TIMEOUT = 64,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rd,
    input  logic [9:0]       cmd_addr,
    input  logic [15:0]      cmd_wdata,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_rdata,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic [11:0]      if_caddr,
    output logic [15:0]      if_wr_data,
    input  logic [15:0]      if_rd_data,
    input  logic             if_rw_ready,
    output logic             busy
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_ENT_W = 1 + 10 + 16 + TAG_W;
    localparam int c_CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_BUSY_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_DONE_LAST = c_CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_ENT_W-1:0] r_mem [c_DEPTH];
    logic [FIFO_AW:0]   r_wptr;
    logic [FIFO_AW:0]   r_rptr;
    logic               r_rd;
    logic [9:0]         r_addr;
    logic [15:0]        r_wdata;
    logic [TAG_W-1:0]   r_tag;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_rdata;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [1:0]         r_rsp_err;
    logic [11:0]        r_if_caddr;
    logic [15:0]        r_if_wr_data;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;
    logic               w_head_rd;
    logic [9:0]         w_head_addr;
    logic [15:0]        w_head_wdata;
    logic [TAG_W-1:0]   w_head_tag;
    logic [c_CNT_W-1:0] w_cnt_inc;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    assign w_head       = r_mem[r_rptr[FIFO_AW-1:0]];
    assign w_head_rd    = w_head[c_ENT_W-1];
    assign w_head_addr  = w_head[c_ENT_W-2 -: 10];
    assign w_head_wdata = w_head[TAG_W +: 16];
    assign w_head_tag   = w_head[TAG_W-1:0];

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);

    assign cmd_ready  = !w_full;
    assign busy       = !w_empty || (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;
    assign if_caddr   = r_if_caddr;
    assign if_wr_data = r_if_wr_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= {cmd_rd, cmd_addr, cmd_wdata, cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= '0;
            r_if_caddr   <= '0;
            r_if_wr_data <= '0;
        end else begin
            r_cnt <= w_cnt_inc;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_rd    <= w_head_rd;
                        r_addr  <= w_head_addr;
                        r_wdata <= w_head_wdata;
                        r_tag   <= w_head_tag;
                        r_cnt   <= '0;
                        if (w_head_addr[0]) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 2'd1;
                            r_rsp_rdata <= '0;
                            r_rsp_tag   <= w_head_tag;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (if_rw_ready) begin
                        r_if_caddr   <= {1'b1, r_rd, r_addr};
                        r_if_wr_data <= r_wdata;
                        r_cnt        <= '0;
                        r_state      <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    // Strobe lasts only the first cycle here; address and rd stay put
                    r_if_caddr[11] <= 1'b0;
                    if (!if_rw_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt >= c_BUSY_LAST) begin
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 2'd2;
                        r_rsp_rdata <= '0;
                        r_rsp_tag   <= r_tag;
                        r_state     <= S_RESP;
                    end
                end
                S_WAIT_DONE: begin
                    if (if_rw_ready) begin
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 2'd0;
                        r_rsp_rdata <= r_rd ? if_rd_data : 16'h0000;
                        r_rsp_tag   <= r_tag;
                        r_state     <= S_RESP;
                    end else if (r_cnt >= c_DONE_LAST) begin
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 2'd3;
                        r_rsp_rdata <= '0;
                        r_rsp_tag   <= r_tag;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_w5300_reg_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_w5300_reg_cmd_seq
// Function : Self-checking bench: vector table, hand sequences for timeouts,
//            back-pressure and reset, plus random traffic against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_w5300_reg_cmd_seq;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rd;
    logic [9:0]       cmd_addr;
    logic [15:0]      cmd_wdata;
    logic [TAG_W-1:0] cmd_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_rdata;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;
    logic [11:0]      if_caddr;
    logic [15:0]      if_wr_data;
    logic [15:0]      if_rd_data;
    logic             if_rw_ready;
    logic             busy;

    w5300_reg_cmd_seq #(
        .FIFO_AW(2), .TAG_W(TAG_W), .BUSY_TIMEOUT(64), .DONE_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .if_caddr(if_caddr), .if_wr_data(if_wr_data), .if_rd_data(if_rd_data),
        .if_rw_ready(if_rw_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rd;
        logic [9:0]       addr;
        logic [15:0]      wdata;
        logic [TAG_W-1:0] tag;
        logic [1:0]       err;
        logic [15:0]      rdata;
    } vec_t;

    typedef struct {
        logic [11:0] caddr;
        logic [15:0] wdata;
    } strb_t;

    vec_t        exp_q[$];
    strb_t       strb_q[$];
    vec_t        tbl[8];
    logic [15:0] ref_mem [512];
    logic [15:0] dev_mem [512];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int dev_mode = 0;      // 0 normal, 1 never drops ready, 2 holds ready low
    int drop_dly = 2;
    int up_dly   = 5;
    bit rnd_dly  = 1'b0;
    bit hold_rsp = 1'b0;
    bit bp       = 1'b0;
    logic [TAG_W-1:0] last_tag;
    logic [1:0]       last_err;
    logic [15:0]      last_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Interface model: records every strobe cycle, then runs the busy/ready handshake
    initial begin : dev
        int          phase;
        int          cnt;
        logic [9:0]  a;
        logic        rd;
        logic [15:0] wd;
        phase = 0;
        cnt = 0;
        if_rw_ready = 1'b1;
        if_rd_data  = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
                if_rw_ready = 1'b1;
            end else begin
                if (if_caddr[11]) strb_q.push_back('{if_caddr, if_wr_data});
                case (phase)
                    0: if (if_caddr[11]) begin
                        a = if_caddr[9:0];
                        rd = if_caddr[10];
                        wd = if_wr_data;
                        if (dev_mode == 2) begin
                            if_rw_ready = 1'b0;
                            phase = 3;
                        end else if (dev_mode == 0) begin
                            if (rnd_dly) begin
                                drop_dly = $urandom_range(1, 6);
                                up_dly   = $urandom_range(1, 8);
                            end
                            cnt = drop_dly;
                            phase = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            if_rw_ready = 1'b0;
                            if_rd_data = 16'hBAD0;
                            if (!rd) dev_mem[a[9:1]] = wd;
                            cnt = up_dly;
                            phase = 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt <= 0) begin
                            if_rd_data = rd ? dev_mem[a[9:1]] : 16'hDEAD;
                            if_rw_ready = 1'b1;
                            phase = 0;
                        end
                    end
                    default: if (dev_mode != 2) begin
                        if_rw_ready = 1'b1;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Response consumer and scoreboard
    initial begin : col
        vec_t  e;
        strb_t s;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = hold_rsp ? 1'b0 : (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (!rst && rsp_valid && rsp_ready) begin
                last_tag = rsp_tag;
                last_err = rsp_err;
                last_rdata = rsp_rdata;
                if (exp_q.size() == 0) begin
                    chk("rsp_pending", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_tag", rsp_tag, e.tag);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    if (e.err != 2'd1) begin
                        if (strb_q.size() == 0) begin
                            chk("strobe_count", strb_q.size(), 1);
                        end else begin
                            s = strb_q.pop_front();
                            chk("strobe_caddr", s.caddr, {1'b1, e.rd, e.addr});
                            if (!e.rd) chk("strobe_wdata", s.wdata, e.wdata);
                            chk("caddr_held", if_caddr, {1'b0, e.rd, e.addr});
                        end
                    end else begin
                        chk("no_strobe_misaligned", strb_q.size(), 0);
                    end
                end
            end
        end
    end

    // Offer one command; the expectation comes from the memory model unless given
    task automatic push(input logic rd, input logic [9:0] addr, input logic [15:0] wd,
                        input logic [TAG_W-1:0] tag, input bit given,
                        input logic [1:0] gerr, input logic [15:0] grd);
        vec_t e;
        bit   ok;
        ok = 1'b0;
        e.rd = rd; e.addr = addr; e.wdata = wd; e.tag = tag;
        cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_wdata = wd; cmd_tag = tag;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                if (given) begin
                    e.err = gerr; e.rdata = grd;
                end else if (addr[0]) begin
                    e.err = 2'd1; e.rdata = 16'h0000;
                end else begin
                    e.err = 2'd0;
                    e.rdata = rd ? ref_mem[addr[9:1]] : 16'h0000;
                    if (!rd) ref_mem[addr[9:1]] = wd;
                end
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        if (!ok) chk("cmd_accept", cmd_ready, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
        end
        if (!done) chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_strobe(output int at);
        bit seen;
        seen = 1'b0;
        at = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (if_caddr[11]) begin seen = 1'b1; at = cyc; end
        end
        if (!seen) chk("strobe_seen", if_caddr[11], 1);
    endtask

    task automatic wait_rsp(input int limit, output int at);
        bit seen;
        seen = 1'b0;
        at = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; at = cyc; end
        end
        if (!seen) chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_if_caddr", if_caddr, 0);
        chk("rst_if_wr_data", if_wr_data, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin : wdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   t_s;
        int   t_r;
        int   lat;
        int   seen;
        logic [21:0] snap;
        logic [9:0]  ra;

        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 16'(i * 7);
            dev_mem[i] = 16'(i * 7);
        end
        ref_mem[2] = 16'h1234;
        dev_mem[2] = 16'h1234;

        tbl[0] = '{1'b0, 10'h200, 16'hA5A5, 4'd3, 2'd0, 16'h0000};
        tbl[1] = '{1'b1, 10'h004, 16'h0000, 4'd5, 2'd0, 16'h1234};
        tbl[2] = '{1'b0, 10'h003, 16'h5555, 4'd7, 2'd1, 16'h0000};
        tbl[3] = '{1'b1, 10'h200, 16'h0000, 4'd9, 2'd0, 16'hA5A5};
        tbl[4] = '{1'b1, 10'h3FF, 16'h0000, 4'd1, 2'd1, 16'h0000};
        tbl[5] = '{1'b0, 10'h3FE, 16'hFFFF, 4'd2, 2'd0, 16'h0000};
        tbl[6] = '{1'b1, 10'h3FE, 16'h0000, 4'd4, 2'd0, 16'hFFFF};
        tbl[7] = '{1'b1, 10'h000, 16'h0000, 4'd0, 2'd0, 16'h0000};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_tag = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        // Vector table: drop ready 2 cycles after strobe, raise it 5 later
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].tag, 1'b0, 2'd0, 16'h0);
            wait_drain(200);
            chk("tbl_tag", last_tag, tbl[i].tag);
            chk("tbl_err", last_err, tbl[i].err);
            chk("tbl_rdata", last_rdata, tbl[i].rdata);
            chk("tbl_extra_strobes", strb_q.size(), 0);
        end

        // FIFO fills while the first access is stalled
        up_dly = 60;
        push(1'b0, 10'h010, 16'h1111, 4'd1, 1'b0, 2'd0, 16'h0);
        wait_strobe(t_s);
        push(1'b1, 10'h010, 16'h0000, 4'd2, 1'b0, 2'd0, 16'h0);
        push(1'b0, 10'h010, 16'h2222, 4'd3, 1'b0, 2'd0, 16'h0);
        push(1'b1, 10'h012, 16'h0000, 4'd4, 1'b0, 2'd0, 16'h0);
        push(1'b1, 10'h011, 16'h0000, 4'd5, 1'b0, 2'd0, 16'h0);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        push(1'b1, 10'h010, 16'h0000, 4'd6, 1'b0, 2'd0, 16'h0);
        wait_drain(1000);
        up_dly = 5;

        // Busy timeout: ready never falls
        dev_mode = 1;
        push(1'b1, 10'h020, 16'h0000, 4'hA, 1'b1, 2'd2, 16'h0000);
        wait_strobe(t_s);
        wait_rsp(200, t_r);
        lat = t_r - t_s;
        chk("busy_timeout_latency", (lat >= 64 && lat <= 65), 1);
        wait_drain(50);

        // Done timeout: ready held low, then the next command runs normally
        dev_mode = 2;
        push(1'b1, 10'h022, 16'h0000, 4'hB, 1'b1, 2'd3, 16'h0000);
        wait_strobe(t_s);
        wait_rsp(1200, t_r);
        lat = t_r - t_s;
        chk("done_timeout_latency", (lat >= 1024 && lat <= 1026), 1);
        dev_mode = 0;
        wait_drain(50);
        push(1'b1, 10'h004, 16'h0000, 4'hC, 1'b0, 2'd0, 16'h0);
        wait_drain(200);
        chk("after_timeout_err", last_err, 0);

        // Random traffic with random handshake delays and response back-pressure
        rnd_dly = 1'b1;
        bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ra[0] = 1'b0;
            push(1'($urandom_range(0, 1)), ra, 16'($urandom), 4'($urandom), 1'b0, 2'd0, 16'h0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        wait_drain(5000);
        rnd_dly = 1'b0;
        bp = 1'b0;
        drop_dly = 2;
        up_dly = 5;

        // Held response stays stable and blocks the queued command
        hold_rsp = 1'b1;
        push(1'b1, 10'h004, 16'h0000, 4'hD, 1'b0, 2'd0, 16'h0);
        push(1'b1, 10'h006, 16'h0000, 4'hE, 1'b0, 2'd0, 16'h0);
        wait_rsp(200, t_r);
        snap = {rsp_tag, rsp_err, rsp_rdata};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_stable", {rsp_tag, rsp_err, rsp_rdata}, snap);
            chk("hold_no_strobe", if_caddr[11], 0);
        end
        hold_rsp = 1'b0;
        wait_drain(300);

        // Reset during WAIT_DONE drops everything
        up_dly = 30;
        push(1'b1, 10'h004, 16'h0000, 4'h9, 1'b0, 2'd0, 16'h0);
        push(1'b1, 10'h008, 16'h0000, 4'h8, 1'b0, 2'd0, 16'h0);
        wait_strobe(t_s);
        for (int i = 0; i < 20 && if_rw_ready; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        exp_q.delete();
        strb_q.delete();
        rst = 1'b0;
        up_dly = 5;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_caddr[11]) seen++;
        end
        chk("no_restrobe_after_rst", seen, 0);
        chk("idle_after_rst", busy, 0);
        push(1'b1, 10'h004, 16'h0000, 4'h7, 1'b0, 2'd0, 16'h0);
        wait_drain(200);
        chk("recover_tag", last_tag, 4'h7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
